// File: rtl/pipeline_pkg.sv
// Shared types and widths for the pipeline hazard sequencer.
// Counter widths are sized for the largest legal parameter values.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    MULDIV_BUSY = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MULDIV_MAX      = 64;
  localparam int         MEM_TIMEOUT_MAX = 255;
  localparam int         BUSY_W          = $clog2(MULDIV_MAX + 1);
  localparam int         WAIT_W          = $clog2(MEM_TIMEOUT_MAX + 1);

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
// A load targeting $0 never creates a dependency.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirects,
// data-memory wait states with timeout, and multi-cycle MULT/DIV occupancy of EX.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_muldiv,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam bit               MULDIV_MULTI = (MULDIV_CYCLES > 1);
  localparam logic [BUSY_W-1:0] BUSY_LOAD   = BUSY_W'(MULDIV_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MEM_TIMEOUT);

  hazard_state_t     state, state_nxt;
  logic [BUSY_W-1:0] busy_cnt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use;
  logic              mem_stall;
  logic              front_active;
  logic              run_hold;
  logic              muldiv_start;

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  assign mem_stall    = mem_req && !mem_ready;
  assign front_active = (state == RUN) || (state == MEM_WAIT);
  // MEM_WAIT only releases on mem_ready; RUN stalls on a fresh miss.
  assign run_hold     = ((state == RUN) && mem_stall) || ((state == MEM_WAIT) && !mem_ready);
  assign muldiv_start = front_active && !run_hold && !ex_redirect && !load_use && id_muldiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN, MEM_WAIT: begin
        if (run_hold)                          state_nxt = MEM_WAIT;
        else if (muldiv_start && MULDIV_MULTI) state_nxt = MULDIV_BUSY;
        else                                   state_nxt = RUN;
      end
      MULDIV_BUSY: begin
        if (!mem_stall && (busy_cnt == BUSY_W'(1))) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state == MULDIV_BUSY) begin
      // EX holds the muldiv op; drain EX/MEM with bubbles unless memory stalls.
      if (!mem_stall) begin
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
      end
    end else if (!run_hold) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if ((state == RUN) && mem_stall) begin
      wait_cnt_nxt = WAIT_W'(1);
    end else if (state == MEM_WAIT) begin
      if (!mem_ready) begin
        if (wait_cnt < WAIT_LIMIT) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == WAIT_LIMIT) mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (muldiv_start && MULDIV_MULTI) begin
      busy_cnt <= BUSY_LOAD;
    end else if ((state == MULDIV_BUSY) && !mem_stall) begin
      busy_cnt <= busy_cnt - BUSY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         stall_cycles <= '0;
    else if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic checked against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MC = 4;
  localparam int TO = 3;

  // Output vector order: pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f
  localparam logic [7:0] O_RESET  = 8'b00000_111;
  localparam logic [7:0] O_NORMAL = 8'b11111_000;
  localparam logic [7:0] O_HOLD   = 8'b00000_000;
  localparam logic [7:0] O_REDIR  = 8'b11111_110;
  localparam logic [7:0] O_LU     = 8'b00111_010;
  localparam logic [7:0] O_BUSY   = 8'b00011_001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_muldiv, ex_memread, ex_redirect, mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, mem_timeout;
  logic [31:0] stall_cycles;
  logic [7:0]  outs;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining front-end hold cycles of a muldiv, pending memory wait.
  int          m_busy;
  bit          m_wait;
  int          m_wait_n;
  bit          m_to;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(MC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv(id_muldiv), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  function automatic bit model_lu();
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [7:0] model_outs();
    bit sm;
    sm = mem_req && !mem_ready;
    if (rst) return O_RESET;
    if (m_busy > 0) return sm ? O_HOLD : O_BUSY;
    if (m_wait ? !mem_ready : sm) return O_HOLD;
    if (ex_redirect) return O_REDIR;
    if (model_lu()) return O_LU;
    return O_NORMAL;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_wait_n = 0; m_to = 0; m_stall = '0;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic md, input logic mr, input logic [4:0] ert,
                       input logic red, input logic mreq, input logic mrdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_muldiv = md; ex_memread = mr;
    ex_rt = ert; ex_redirect = red; mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    logic [7:0] o;
    bit sm, lu;
    o  = model_outs();
    sm = mem_req && !mem_ready;
    lu = model_lu();
    if (m_busy > 0) begin
      if (!sm) m_busy--;
    end else if (m_wait && !mem_ready) begin
      if (m_wait_n < TO) m_wait_n++;
      if (m_wait_n == TO) m_to = 1;
    end else if (!m_wait && sm) begin
      m_wait   = 1;
      m_wait_n = 1;
      if (m_wait_n == TO) m_to = 1;
    end else begin
      m_wait   = 0;
      m_wait_n = 0;
      if (!ex_redirect && !lu && id_muldiv && MC > 1) m_busy = MC - 1;
    end
    if (!o[7]) m_stall++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL reset_outs got %b want %b", outs, O_RESET);
    end
    checks++;
    if (mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_regs got to=%b stall=%0d want 0/0", mem_timeout, stall_cycles);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL reset_release got %b want %b", outs, O_NORMAL);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_bubble got %b want %b", outs, O_LU);
    end
    tick();
    idle();
    #1;
    checks++;
    if (outs !== O_NORMAL || stall_cycles !== 32'd1) begin
      errors++; $display("FAIL load_use_after got %b stall=%0d want %b stall=1", outs, stall_cycles, O_NORMAL);
    end
    // rt match only counts when the instruction actually reads rt
    drive(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rt got %b want %b", outs, O_LU);
    end
    drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL load_use_rt_unused got %b want %b", outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_load_r0();
    do_reset();
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL load_r0 got %b want %b", outs, O_NORMAL);
    end
    tick();
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL load_r0_stall got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    drive(5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_REDIR) begin
      errors++; $display("FAIL redirect_lu got %b want %b", outs, O_REDIR);
    end
    tick();
    idle();
    #1;
    checks++;
    if (outs !== O_NORMAL || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL redirect_after got %b stall=%0d want %b stall=0", outs, stall_cycles, O_NORMAL);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    // Load-use and muldiv together: bubble first, muldiv starts next cycle.
    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL muldiv_lu_first got %b want %b", outs, O_LU);
    end
    tick();
    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL muldiv_start got %b want %b", outs, O_NORMAL);
    end
    tick();
    idle();
    for (int i = 0; i < MC - 1; i++) begin
      #1;
      checks++;
      if (outs !== O_BUSY) begin
        errors++; $display("FAIL muldiv_busy[%0d] got %b want %b", i, outs, O_BUSY);
      end
      tick();
    end
    #1;
    checks++;
    if (outs !== O_NORMAL || stall_cycles !== 32'(MC)) begin
      errors++; $display("FAIL muldiv_done got %b stall=%0d want %b stall=%0d", outs, stall_cycles, O_NORMAL, MC);
    end
  endtask

  task automatic test_muldiv_mem_stall();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < MC + 1; i++) begin
      idle();
      if (i == 1 || i == 2) begin
        mem_req = 1'b1; mem_ready = 1'b0;
      end
      #1;
      checks++;
      if (outs !== ((i == 1 || i == 2) ? O_HOLD : O_BUSY)) begin
        errors++; $display("FAIL busy_mem[%0d] got %b want %b", i, outs, (i == 1 || i == 2) ? O_HOLD : O_BUSY);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (outs !== O_NORMAL || stall_cycles !== 32'(MC + 1)) begin
      errors++; $display("FAIL busy_mem_done got %b stall=%0d want %b stall=%0d", outs, stall_cycles, O_NORMAL, MC + 1);
    end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO + 1; i++) begin
      #1;
      checks++;
      if (outs !== O_HOLD || mem_timeout !== (i >= TO)) begin
        errors++; $display("FAIL mem_wait[%0d] got %b to=%b want %b to=%b", i, outs, mem_timeout, O_HOLD, i >= TO);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL mem_ready_release got %b want %b", outs, O_NORMAL);
    end
    tick();
    idle();
    #1;
    checks++;
    if (mem_timeout !== 1'b1 || stall_cycles !== 32'(TO + 1)) begin
      errors++; $display("FAIL mem_timeout_sticky got to=%b stall=%0d want 1 stall=%0d", mem_timeout, stall_cycles, TO + 1);
    end
    tick();
    do_reset();
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL mem_timeout_clear got %b want 0", mem_timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_RESET || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL async_reset got %b stall=%0d want %b stall=0", outs, stall_cycles, O_RESET);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL async_release got %b want %b", outs, O_NORMAL);
    end
    tick();
    checks++;
    if (outs !== O_NORMAL || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL async_run got %b stall=%0d want %b stall=0", outs, stall_cycles, O_NORMAL);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) do_reset();
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom % 2),
            1'($urandom_range(0, 5) == 0), 1'($urandom % 2), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 5) == 0), 1'($urandom % 2), 1'($urandom_range(0, 3) != 0));
      #1;
      exp = model_outs();
      checks++;
      if (outs !== exp || mem_timeout !== m_to || stall_cycles !== m_stall) begin
        errors++;
        $display("FAIL random[%0d] got %b to=%b stall=%0d want %b to=%b stall=%0d",
                 i, outs, mem_timeout, stall_cycles, exp, m_to, m_stall);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_load_r0();
    test_redirect_load_use();
    test_muldiv();
    test_muldiv_mem_stall();
    test_mem_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the load enables and bubble-insert controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves load-use hazards, branch/jump redirects, data-memory wait states with timeout, and multi-cycle MULT/DIV occupancy of EX. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- MULDIV_CYCLES, 32, EX occupancy of a MULT/DIV op in cycles (1..64)
- MEM_TIMEOUT, 255, max consecutive MEM wait cycles before error (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_muldiv  in  1  ID instruction is MULT/DIV
- ex_memread  in  1  MemRead of instruction in EX (ID/EX output)
- ex_rt  in  5  rt (load destination) of instruction in EX
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_req  in  1  MEM stage instruction issues MemRead or MemWrite
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load zeros (bubble) instead of data when the enable is 1
- mem_timeout  out  1  sticky error; cleared only by rst
- stall_cycles  out  32  count of cycles with pc_en=0

## Operation
State register: RUN, MEM_WAIT, MULDIV_BUSY. Outputs are combinational from state and inputs (Mealy), so hazards act in the cycle they appear.
- Load-use: ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority in RUN: mem stall > redirect > load-use > muldiv start > normal.
- Mem stall (mem_req && !mem_ready): all enables 0, all flushes 0. Go to MEM_WAIT and load wait_cnt=1.
- Redirect: all enables 1, ifid_flush=1, idex_flush=1. Load-use is ignored because the offending instruction is squashed.
- Load-use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1.
- Muldiv start: normal enables. If MULDIV_CYCLES>1, load busy_cnt=MULDIV_CYCLES-1 and go to MULDIV_BUSY.
- Normal: all enables 1, all flushes 0.
- MEM_WAIT: all enables 0. Each cycle with !mem_ready, wait_cnt increments, saturating at MEM_TIMEOUT. When wait_cnt reaches MEM_TIMEOUT, set mem_timeout and stay in MEM_WAIT. On mem_ready, apply RUN rules for that cycle (ignoring the mem stall term) and return to RUN.
- MULDIV_BUSY: pc_en=ifid_en=idex_en=0, exmem_en=1 with exmem_flush=1, memwb_en=1. busy_cnt decrements each cycle; the cycle it is 1 is the last BUSY cycle, and the FSM then returns to RUN.
  - A mem stall in BUSY sets all enables 0 and holds busy_cnt. The FSM stays in BUSY and does not enter MEM_WAIT.
  - A redirect in BUSY is impossible because EX holds the muldiv op; ex_redirect is ignored.
- stall_cycles increments on every cycle with pc_en=0 and wraps modulo 2^32.

## Timing
- Reset asserted: state=RUN, busy_cnt=wait_cnt=0, mem_timeout=0, stall_cycles=0. All enables 0, ifid_flush=idex_flush=exmem_flush=1. Release is synchronous to the next clk edge.
- Load-use costs exactly 1 bubble.
- Redirect costs 2 squashed slots.
- Muldiv holds the front end for MULDIV_CYCLES-1 cycles.
- Mem stall lasts until the cycle mem_ready=1 inclusive. Zero added latency when mem_ready is already high.
- Simultaneous load-use and muldiv in ID: load-use wins; muldiv starts the cycle after the bubble.
- rst mid-BUSY or mid-MEM_WAIT: immediate return to RUN, counters cleared.

## Structure
- Shared package pipeline_pkg: state enum (RUN, MEM_WAIT, MULDIV_BUSY), REG_ZERO=5'd0, counter widths derived via $clog2.
- One sub-module, load_use_detect: combinational comparator producing the load-use term. The FSM, counters and output decode stay in the top module.

## Test plan
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0→1.
- Load to $0: ex_rt=0, id_rs=0 → no stall, all enables 1.
- Redirect together with load-use: ex_redirect=1 and a load-use match → pc_en=1, ifid_flush=1, idex_flush=1, no stall.
- Muldiv with MULDIV_CYCLES=4: id_muldiv=1 → 3 BUSY cycles with exmem_flush=1 and pc_en=0, then RUN.
  - Variant: a 2-cycle mem stall inside BUSY extends the front-end hold to 5 cycles.
- Memory timeout with MEM_TIMEOUT=3: mem_req=1, mem_ready=0 held → mem_timeout rises after 3 wait cycles and stays high after mem_ready=1; only rst clears it.
- Async reset mid-BUSY: assert rst between edges → enables drop to 0 immediately; after release the FSM is in RUN with stall_cycles=0.
